// File: rtl/apb_slv_pkg.sv
// Shared types and constants for the APB register-file slave.
package apb_slv_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int WAIT_MAX   = 15;
    localparam int CNT_W      = $clog2(WAIT_MAX + 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

endpackage

// File: rtl/apb_slv_mem.sv
// DEPTH x DATA_W byte store: cleared on reset, one synchronous write port, one combinational read port.
module apb_slv_mem #(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 8,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Storage array with full clear on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end else begin
            mem_r[waddr] <= mem_r[waddr];
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/apb_mem_slave.sv
// APB register-file slave with programmable wait states and out-of-range error response.
// Optional protocol checking enabled by defining APB_SLV_PROT_CHK_EN.
module apb_mem_slave
    import apb_slv_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              prot_err
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t            state_r, state_n;
    logic [ADDR_W-1:0] addr_r, addr_n;
    logic              write_r, write_n;
    logic [DATA_W-1:0] wdata_r, wdata_n;
    logic [CNT_W-1:0]  cnt_r, cnt_n;
    logic              pready_r, pready_n;
    logic              pslverr_r, pslverr_n;
    logic [DATA_W-1:0] prdata_r, prdata_n;
    logic              xerr_r, xerr_n;
    logic              mem_we_s;
    logic              mismatch_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic              sel_write_s;
    logic [DATA_W-1:0] mem_rdata_s;
    logic [DATA_W-1:0] rd_data_s;
    logic              resp_err_s;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (32'(a) < DEPTH);
    endfunction

    apb_slv_mem #(.DEPTH(DEPTH), .DATA_W(DATA_W), .IDX_W(IDX_W)) u_mem (
        .clk   (pclk),
        .rst   (preset),
        .we    (mem_we_s),
        .waddr (addr_r[IDX_W-1:0]),
        .wdata (wdata_r),
        .raddr (sel_addr_s[IDX_W-1:0]),
        .rdata (mem_rdata_s)
    );

`ifdef APB_SLV_PROT_CHK_EN
    assign mismatch_s = (state_r == ACCESS) && psel &&
                        ((paddr != addr_r) || (pwrite != write_r) ||
                         (write_r && (pwdata != wdata_r)));

    // Sticky protocol-violation flag, cleared only by reset
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            prot_err <= 1'b0;
        end else if (mismatch_s || ((state_r == IDLE) && psel && penable)) begin
            prot_err <= 1'b1;
        end else begin
            prot_err <= prot_err;
        end
    end
`else
    assign mismatch_s = 1'b0;
    assign prot_err   = 1'b0;
`endif

    // In IDLE the response is formed from the live bus, afterwards from the latched request
    assign sel_addr_s  = (state_r == IDLE) ? paddr  : addr_r;
    assign sel_write_s = (state_r == IDLE) ? pwrite : write_r;
    assign rd_data_s   = (!sel_write_s && addr_ok(sel_addr_s)) ? mem_rdata_s : {DATA_W{1'b0}};
    assign resp_err_s  = !addr_ok(sel_addr_s) ||
                         ((state_r == ACCESS) && (xerr_r || mismatch_s));

    // Next-state, wait counter and response logic
    always_comb begin
        state_n   = state_r;
        addr_n    = addr_r;
        write_n   = write_r;
        wdata_n   = wdata_r;
        cnt_n     = cnt_r;
        pready_n  = pready_r;
        pslverr_n = pslverr_r;
        prdata_n  = prdata_r;
        xerr_n    = xerr_r;
        mem_we_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (psel && !penable) begin
                    state_n = ACCESS;
                    addr_n  = paddr;
                    write_n = pwrite;
                    wdata_n = pwdata;
                    cnt_n   = CNT_W'(WAIT_CYCLES);
                    xerr_n  = 1'b0;
                    if (WAIT_CYCLES == 0) begin
                        pready_n  = 1'b1;
                        prdata_n  = rd_data_s;
                        pslverr_n = resp_err_s;
                    end else begin
                        pready_n  = 1'b0;
                    end
                end else begin
                    pready_n = 1'b0;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_n   = IDLE;
                    pready_n  = 1'b0;
                    pslverr_n = 1'b0;
                    prdata_n  = {DATA_W{1'b0}};
                end else if (pready_r) begin
                    if (penable) begin
                        mem_we_s  = write_r && addr_ok(addr_r) && !xerr_r && !mismatch_s;
                        state_n   = IDLE;
                        pready_n  = 1'b0;
                        pslverr_n = 1'b0;
                        prdata_n  = {DATA_W{1'b0}};
                    end else begin
                        state_n = ACCESS;
                    end
                end else begin
                    cnt_n = cnt_r - CNT_W'(1);
                    if (mismatch_s) begin
                        xerr_n = 1'b1;
                    end else begin
                        xerr_n = xerr_r;
                    end
                    if (cnt_r == CNT_W'(1)) begin
                        pready_n  = 1'b1;
                        prdata_n  = rd_data_s;
                        pslverr_n = resp_err_s;
                    end else begin
                        pready_n  = 1'b0;
                    end
                end
            end
            default: begin
                state_n   = IDLE;
                pready_n  = 1'b0;
                pslverr_n = 1'b0;
                prdata_n  = {DATA_W{1'b0}};
            end
        endcase
    end

    // State and response registers
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_r   <= IDLE;
            addr_r    <= {ADDR_W{1'b0}};
            write_r   <= 1'b0;
            wdata_r   <= {DATA_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
            prdata_r  <= {DATA_W{1'b0}};
            xerr_r    <= 1'b0;
        end else begin
            state_r   <= state_n;
            addr_r    <= addr_n;
            write_r   <= write_n;
            wdata_r   <= wdata_n;
            cnt_r     <= cnt_n;
            pready_r  <= pready_n;
            pslverr_r <= pslverr_n;
            prdata_r  <= prdata_n;
            xerr_r    <= xerr_n;
        end
    end

    assign pready  = pready_r;
    assign pslverr = pslverr_r;
    assign prdata  = prdata_r;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Scoreboard bench for apb_mem_slave: instance 0 has no wait states, instance 1 has three.
module tb_apb_mem_slave;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         waits;
    } exp_t;

    logic       clk;
    logic       preset;
    logic       psel    [2];
    logic       penable [2];
    logic       pwrite  [2];
    logic [7:0] paddr   [2];
    logic [7:0] pwdata  [2];
    logic [7:0] prdata  [2];
    logic       pready  [2];
    logic       pslverr [2];
    logic       prot_err[2];

    logic [7:0] model [2][256];
    exp_t       sb[$];
    int         n_chk  = 0;
    int         n_fail = 0;
    logic       prot_exp;

    apb_mem_slave #(.ADDR_W(8), .DATA_W(8), .DEPTH(64), .WAIT_CYCLES(0)) dut0 (
        .pclk(clk), .preset(preset), .psel(psel[0]), .penable(penable[0]),
        .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]),
        .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0]), .prot_err(prot_err[0])
    );

    apb_mem_slave #(.ADDR_W(8), .DATA_W(8), .DEPTH(64), .WAIT_CYCLES(3)) dut1 (
        .pclk(clk), .preset(preset), .psel(psel[1]), .penable(penable[1]),
        .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]),
        .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1]), .prot_err(prot_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < 256; a++) begin
                model[d][a] = 8'h00;
            end
        end
    endtask

    task automatic check_idle_outputs(input int d, input string tag);
        check({tag, "_prdata"},  32'(prdata[d]),   32'h0);
        check({tag, "_pready"},  32'(pready[d]),   32'h0);
        check({tag, "_pslverr"}, 32'(pslverr[d]),  32'h0);
        check({tag, "_prot"},    32'(prot_err[d]), 32'h0);
    endtask

    // One complete transfer; glitch flips paddr bit 0 after the first wait cycle.
    task automatic xfer(input int d, input bit wr, input logic [7:0] a,
                        input logic [7:0] wd, input bit glitch, input string tag);
        exp_t e;
        int   waits;
        bit   done;
        e.err   = (a >= 8'd64);
`ifdef APB_SLV_PROT_CHK_EN
        if (glitch) e.err = 1'b1;
`endif
        e.data  = (wr || e.err) ? 8'h00 : model[d][a];
        e.waits = (d == 0) ? 0 : 3;
        sb.push_back(e);
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
        @(posedge clk); #1;
        penable[d] = 1'b1;
        waits = 0;
        done  = 1'b0;
        while (!done && waits <= 20) begin
            @(negedge clk);
            if (pready[d]) begin
                done = 1'b1;
            end else begin
                waits++;
                if (glitch && waits == 1) paddr[d] = a ^ 8'h01;
            end
        end
        e = sb.pop_front();
        if (!done) begin
            check({tag, "_timeout"}, 32'h0, 32'h1);
            psel[d] = 1'b0; penable[d] = 1'b0;
        end else begin
            check({tag, "_waits"},   32'(waits),      32'(e.waits));
            check({tag, "_prdata"},  32'(prdata[d]),  32'(e.data));
            check({tag, "_pslverr"}, 32'(pslverr[d]), 32'(e.err));
            @(posedge clk); #1;
            psel[d] = 1'b0; penable[d] = 1'b0;
            if (wr && !e.err) model[d][a] = wd;
            check({tag, "_pready_drop"}, 32'(pready[d]), 32'h0);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
            paddr[d] = 8'h00; pwdata[d] = 8'h00;
        end
        clear_model();
        preset = 1'b1;
        repeat (2) @(posedge clk);
        #1 preset = 1'b0;
        @(negedge clk);
        check_idle_outputs(0, "rst0");
        check_idle_outputs(1, "rst1");

        // zero-wait write/read
        @(posedge clk); #1;
        xfer(0, 1'b1, 8'h10, 8'hA5, 1'b0, "w0_10");
        xfer(0, 1'b0, 8'h10, 8'h00, 1'b0, "r0_10");

        // three wait states
        xfer(1, 1'b1, 8'h05, 8'h3C, 1'b0, "w1_05");
        xfer(1, 1'b0, 8'h05, 8'h00, 1'b0, "r1_05");

        // out-of-range write leaves memory untouched
        xfer(0, 1'b1, 8'h00, 8'h5A, 1'b0, "w0_00");
        xfer(0, 1'b1, 8'h40, 8'h77, 1'b0, "w0_40");
        xfer(0, 1'b0, 8'h00, 8'h00, 1'b0, "r0_00");
        xfer(0, 1'b0, 8'h40, 8'h00, 1'b0, "r0_40");
        xfer(0, 1'b0, 8'h3F, 8'h00, 1'b0, "r0_3f");

        // back-to-back transfers
        xfer(0, 1'b1, 8'h01, 8'h01, 1'b0, "bb_w1");
        xfer(0, 1'b1, 8'h02, 8'h02, 1'b0, "bb_w2");
        xfer(0, 1'b0, 8'h01, 8'h00, 1'b0, "bb_r1");
        xfer(0, 1'b0, 8'h02, 8'h00, 1'b0, "bb_r2");

        // psel with penable in IDLE gets no response
`ifdef APB_SLV_PROT_CHK_EN
        prot_exp = 1'b1;
`else
        prot_exp = 1'b0;
`endif
        psel[0] = 1'b1; penable[0] = 1'b1; paddr[0] = 8'h10; pwrite[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_pen_pready", 32'(pready[0]), 32'h0);
        end
        psel[0] = 1'b0; penable[0] = 1'b0;
        check("idle_pen_prot", 32'(prot_err[0]), 32'(prot_exp));

        // address changed mid-access
        xfer(1, 1'b1, 8'h08, 8'h55, 1'b1, "glitch_w");
        check("glitch_prot", 32'(prot_err[1]), 32'(prot_exp));
        xfer(1, 1'b0, 8'h08, 8'h00, 1'b0, "glitch_r08");
        xfer(1, 1'b0, 8'h09, 8'h00, 1'b0, "glitch_r09");
        check("glitch_prot_sticky", 32'(prot_err[1]), 32'(prot_exp));

        // reset during the wait of a write
        xfer(1, 1'b1, 8'h03, 8'h11, 1'b0, "pre_w03");
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 8'h03; pwdata[1] = 8'hFF;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        @(negedge clk);
        preset = 1'b1;
        #1;
        check_idle_outputs(1, "midrst");
        psel[1] = 1'b0; penable[1] = 1'b0;
        clear_model();
        @(posedge clk); #1;
        preset = 1'b0;
        @(posedge clk); #1;
        xfer(1, 1'b0, 8'h03, 8'h00, 1'b0, "post_r03");
        xfer(0, 1'b0, 8'h10, 8'h00, 1'b0, "post_r10");
        check("post_prot0", 32'(prot_err[0]), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
